mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory bus, directly downstream of the Memory stage.
- Consumes the M-stage outputs MemWrite, the address (OpResult) and WriteData.
- Returns register read data combinationally in the same cycle, because the core samples ReadData into the M/W pipeline register.
- Top-level muxes ReadData between this block and data memory using Hit; a TX FIFO decouples CPU stores from the serial shifter.

---
 rtl/mmio_uart_tx_pkg.sv | 36 +++
 rtl/mmio_uart_tx_if.sv | 28 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 64 ++++++
 rtl/mmio_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout, shifter states and the baud reload helper.
package uart_mmio_pkg;

  // Register select values taken from Addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS register layout
  localparam int ST_FULL_BIT   = 0;
  localparam int ST_EMPTY_BIT  = 1;
  localparam int ST_BUSY_BIT   = 2;
  localparam int ST_OVR_BIT    = 3;
  localparam int ST_TXEN_BIT   = 4;
  localparam int ST_COUNT_LSB  = 8;

  // Bit in a STATUS write that clears the sticky overrun flag
  localparam int ST_OVR_CLR_BIT = 3;

  // Shifter states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Baud counter reload for one bit period; a divisor of 0 behaves as 1.
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    if (div == 16'd0) begin
      return 16'd0;
    end
    return div - 16'd1;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART: M-stage store strobe, address and
// data in, combinational hit and read data back to the core.
interface mmio_uart_tx_if;
  // Bus handshake: a store completes in the single cycle where MemWrite and
  // Hit are both high; there is no stall or backpressure. Reads are purely
  // combinational on Addr and return pre-edge register state.
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        Hit;
  logic [31:0] ReadData;

  modport master (
    output MemWrite,
    output Addr,
    output WriteData,
    input  Hit,
    input  ReadData
  );

  modport slave (
    input  MemWrite,
    input  Addr,
    input  WriteData,
    output Hit,
    output ReadData
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with a combinational head output; pops on empty and
// pushes on full (without a same-cycle pop) are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      cnt;
  logic             doPush;
  logic             doPop;

  assign full  = (cnt == DEPTH_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rdPtr];

  // A push into a full FIFO is legal when the head leaves in the same cycle;
  // the write slot is then the one being vacated.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge CLK) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window on the data bus, a TX
// FIFO decoupling stores from the serial shifter, and a programmable baud.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0800,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic               CLK,
  input  logic               Reset,
  mmio_uart_tx_if.slave      bus,
  output logic               TxD,
  output logic               TxBusy,
  output logic [1:0]         dbgState
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Register state
  logic [15:0]  baudDiv;
  logic         txEn;
  logic         ovr;

  // Decode
  logic         hit;
  logic [1:0]   regSel;
  logic         wr;
  logic         txDataWr;
  logic         statusWr;
  logic         baudWr;
  logic         ctrlWr;
  logic [31:0]  statusWord;
  logic [31:0]  readMux;
  logic         unusedBits;

  // FIFO
  logic         fifoPop;
  logic [7:0]   fifoDout;
  logic         fifoFull;
  logic         fifoEmpty;
  logic [CW-1:0] fifoCount;

  // Shifter
  logic [1:0]   state;
  logic [7:0]   shreg;
  logic [15:0]  baudCnt;
  logic [2:0]   bitCnt;
  logic         txdReg;
  logic [15:0]  reload;
  logic         bitDone;

  assign hit      = (bus.Addr[31:4] == BASE_ADDR[31:4]);
  assign regSel   = bus.Addr[3:2];
  assign wr       = bus.MemWrite & hit;
  assign txDataWr = wr & (regSel == REG_TXDATA);
  assign statusWr = wr & (regSel == REG_STATUS);
  assign baudWr   = wr & (regSel == REG_BAUDDIV);
  assign ctrlWr   = wr & (regSel == REG_CTRL);

  // Byte lanes and address bits the register map never looks at
  assign unusedBits = ^{bus.Addr[1:0], bus.WriteData[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (txDataWr),
    .pop   (fifoPop),
    .din   (bus.WriteData[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      baudDiv <= DEFAULT_DIV;
      txEn    <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      if (baudWr) begin
        baudDiv <= bus.WriteData[15:0];
      end
      if (ctrlWr) begin
        txEn <= bus.WriteData[0];
      end
      // A dropped byte outranks a same-cycle clear so no overrun is lost.
      if (txDataWr & fifoFull & ~fifoPop) begin
        ovr <= 1'b1;
      end else if (statusWr & bus.WriteData[ST_OVR_CLR_BIT]) begin
        ovr <= 1'b0;
      end
    end
  end

  always_comb begin
    statusWord                         = '0;
    statusWord[ST_FULL_BIT]            = fifoFull;
    statusWord[ST_EMPTY_BIT]           = fifoEmpty;
    statusWord[ST_BUSY_BIT]            = TxBusy;
    statusWord[ST_OVR_BIT]             = ovr;
    statusWord[ST_TXEN_BIT]            = txEn;
    statusWord[ST_COUNT_LSB +: CW]     = fifoCount;
  end

  always_comb begin
    readMux = '0;
    if (hit) begin
      case (regSel)
        REG_TXDATA:  readMux = '0;
        REG_STATUS:  readMux = statusWord;
        REG_BAUDDIV: readMux = {16'd0, baudDiv};
        REG_CTRL:    readMux = {31'd0, txEn};
        default:     readMux = '0;
      endcase
    end
  end

  assign bus.Hit      = hit;
  assign bus.ReadData = readMux;

  // The divisor is sampled only when a bit starts, so a BAUDDIV write never
  // stretches or shortens the bit already on the line.
  assign reload   = bit_reload(baudDiv);
  assign bitDone  = (baudCnt == 16'd0);
  assign fifoPop  = (state == IDLE) & txEn & ~fifoEmpty;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      shreg   <= '0;
      baudCnt <= '0;
      bitCnt  <= '0;
      txdReg  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txdReg <= 1'b1;
          if (fifoPop) begin
            shreg   <= fifoDout;
            baudCnt <= reload;
            txdReg  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bitDone) begin
            baudCnt <= reload;
            bitCnt  <= '0;
            txdReg  <= shreg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        DATA: begin
          if (bitDone) begin
            baudCnt <= reload;
            if (bitCnt == 3'd7) begin
              txdReg <= 1'b1;
              state  <= STOP;
            end else begin
              shreg  <= shreg >> 1;
              txdReg <= shreg[1];
              bitCnt <= bitCnt + 3'd1;
            end
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            state <= IDLE;
          end else begin
            baudCnt <= baudCnt - 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          txdReg <= 1'b1;
        end
      endcase
    end
  end

  assign TxD      = txdReg;
  assign TxBusy   = (state != IDLE);
  assign dbgState = state;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-map vector table plus hand-written
// sequences for frame timing, overrun, full-with-pop, baud change and reset.
module tb_mmio_uart_tx;

  logic       CLK;
  logic       Reset;
  logic       TxD;
  logic       TxBusy;
  logic [1:0] dbgState;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0800),
    .FIFO_DEPTH  (16),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .bus      (bus),
    .TxD      (TxD),
    .TxBusy   (TxBusy),
    .dbgState (dbgState)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expHit;
    logic [31:0] expRd;
  } vec_t;

  vec_t        vecs[16];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus.MemWrite  = 1'b1;
    bus.Addr      = a;
    bus.WriteData = d;
    @(posedge CLK);
    #1 bus.MemWrite = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK);
    bus.MemWrite = 1'b0;
    bus.Addr     = a;
    #1 d = bus.ReadData;
  endtask

  task automatic checkReg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    busRead(a, d);
    chk(name, d, exp);
  endtask

  // Exact cycle-by-cycle check of one frame that was just stored into an
  // empty FIFO with the shifter idle.
  task automatic checkFrame(input string name, input logic [7:0] b, input int div);
    logic e;
    @(negedge CLK);
    chk({name, "_idle_txd"}, TxD, 1'b1);
    chk({name, "_idle_busy"}, TxBusy, 1'b0);
    for (int k = 0; k < 10 * div; k++) begin
      @(negedge CLK);
      if (k < div)          e = 1'b0;
      else if (k < 9 * div) e = b[(k / div) - 1];
      else                  e = 1'b1;
      chk({name, "_txd"}, TxD, e);
      chk({name, "_busy"}, TxBusy, 1'b1);
    end
    @(negedge CLK);
    chk({name, "_end_busy"}, TxBusy, 1'b0);
    chk({name, "_end_txd"}, TxD, 1'b1);
  endtask

  task automatic waitIdle(input string name, input int limit);
    bit done;
    done = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge CLK);
      if (TxBusy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_idle_timeout"}, done, 1'b1);
  endtask

  // Serial receiver: samples each bit one or two cycles into its period.
  task automatic rxByte(input int div, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge CLK);
      if (TxD === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge CLK);
        b[i] = TxD;
      end
      repeat (div) @(negedge CLK);
      chk("rx_stop_bit", TxD, 1'b1);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rb;
    logic [7:0]  eb;
    bit          ok;

    vecs[0]  = '{0, 32'h0000_0800, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{0, 32'h0000_0804, 32'h0,         1'b1, 32'h12};
    vecs[2]  = '{0, 32'h0000_0806, 32'h0,         1'b1, 32'h12};
    vecs[3]  = '{0, 32'h0000_0808, 32'h0,         1'b1, 32'd868};
    vecs[4]  = '{0, 32'h0000_080C, 32'h0,         1'b1, 32'h1};
    vecs[5]  = '{0, 32'h0000_0900, 32'h0,         1'b0, 32'h0};
    vecs[6]  = '{1, 32'h0000_0900, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[7]  = '{0, 32'h0000_0804, 32'h0,         1'b1, 32'h12};
    vecs[8]  = '{1, 32'h0000_0908, 32'h5,         1'b0, 32'h0};
    vecs[9]  = '{0, 32'h0000_0808, 32'h0,         1'b1, 32'd868};
    vecs[10] = '{1, 32'h0000_080A, 32'h0003_0007, 1'b1, 32'd868};
    vecs[11] = '{0, 32'h0000_0808, 32'h0,         1'b1, 32'd7};
    vecs[12] = '{1, 32'h0000_080C, 32'h0,         1'b1, 32'h1};
    vecs[13] = '{0, 32'h0000_080C, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{1, 32'h0000_080C, 32'h1,         1'b1, 32'h0};
    vecs[15] = '{0, 32'h0000_07FC, 32'h0,         1'b0, 32'h0};

    Reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.Addr      = 32'h0000_0900;
    bus.WriteData = 32'h0;
    #1;
    chk("rst_txd", TxD, 1'b1);
    chk("rst_busy", TxBusy, 1'b0);
    chk("rst_state", dbgState, 2'd0);
    chk("rst_hit", bus.Hit, 1'b0);
    chk("rst_rdata", bus.ReadData, 32'h0);
    repeat (3) @(negedge CLK);
    Reset = 1'b0;

    // Register map table; ReadData on a write cycle shows pre-edge state
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      bus.MemWrite  = vecs[i].wr;
      bus.Addr      = vecs[i].addr;
      bus.WriteData = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_hit", i), bus.Hit, vecs[i].expHit);
      chk($sformatf("vec%0d_rdata", i), bus.ReadData, vecs[i].expRd);
      @(posedge CLK);
      #1 bus.MemWrite = 1'b0;
    end

    // 0x55 at DIV=4
    busWrite(32'h808, 32'd4);
    busWrite(32'h800, 32'h55);
    checkFrame("f55", 8'h55, 4);

    // DIV=0 behaves as one clock per bit
    busWrite(32'h808, 32'd0);
    checkReg("baud_zero_rd", 32'h808, 32'd0);
    busWrite(32'h800, 32'hA5);
    checkFrame("fa5", 8'hA5, 1);

    // BAUDDIV change while bit 0 is on the line
    busWrite(32'h808, 32'd4);
    busWrite(32'h800, 32'h55);
    repeat (6) @(posedge CLK);
    #1;
    busWrite(32'h808, 32'd8);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("div_chg_bit0", TxD, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("div_chg_bit1", TxD, 1'b0);
    end
    @(negedge CLK);
    chk("div_chg_bit2", TxD, 1'b1);
    waitIdle("div_chg", 200);
    busWrite(32'h808, 32'd4);

    // Overrun with TXEN=0
    busWrite(32'h80C, 32'd0);
    for (int i = 0; i < 16; i++) busWrite(32'h800, 32'h10 + i);
    checkReg("full_no_ovr", 32'h804, 32'h1001);
    busWrite(32'h800, 32'h20);
    checkReg("full_ovr", 32'h804, 32'h1009);
    chk("txen0_txd", TxD, 1'b1);
    chk("txen0_busy", TxBusy, 1'b0);
    busWrite(32'h804, 32'h8);
    checkReg("ovr_clear", 32'h804, 32'h1001);

    // Store on the cycle the shifter pops a full FIFO
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'hC5);
    busWrite(32'h80C, 32'd1);
    busWrite(32'h800, 32'hC5);
    checkReg("full_pop_push", 32'h804, 32'h1015);
    for (int n = 0; n < 17; n++) begin
      rxByte(4, rb, ok);
      if (!ok) begin
        chk("rx_timeout", 32'(ok), 32'd1);
        break;
      end
      eb = exp_q.pop_front();
      chk($sformatf("rx_byte%0d", n), rb, eb);
    end
    chk("rx_left", exp_q.size(), 32'd0);
    repeat (5) @(negedge CLK);
    checkReg("drained_status", 32'h804, 32'h12);

    // Asynchronous reset in the middle of 0xA3 with three bytes queued
    busWrite(32'h800, 32'hA3);
    busWrite(32'h800, 32'h11);
    busWrite(32'h800, 32'h22);
    busWrite(32'h800, 32'h33);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    bus.Addr = 32'h804;
    chk("pre_rst_busy", TxBusy, 1'b1);
    chk("pre_rst_state", dbgState, 2'd2);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_txd", TxD, 1'b1);
    chk("mid_rst_busy", TxBusy, 1'b0);
    chk("mid_rst_status", bus.ReadData, 32'h12);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    checkReg("post_rst_status", 32'h804, 32'h12);
    checkReg("post_rst_baud", 32'h808, 32'd868);
    checkReg("post_rst_ctrl", 32'h80C, 32'h1);
    repeat (10) @(negedge CLK);
    chk("post_rst_txd", TxD, 1'b1);
    chk("post_rst_idle", TxBusy, 1'b0);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
